// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the instruction fetch slice: word width,
// the buffered fetch entry and the fetch control states.
package fetch_unit_pkg;

  localparam int unsigned word_width = 32;

  typedef logic [word_width-1:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instruction;
  } fetch_entry_t;

  typedef enum logic {
    RESET,
    RUN
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order buffer of fetched {pc, instruction} pairs with
// valid/ready on both sides and a synchronous clear.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         clear,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  fetch_entry_t wr_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output fetch_entry_t rd_data,
  output logic [1:0]   count
);

  fetch_entry_t entry_q [2];
  logic [1:0]   count_q;
  logic [1:0]   wr_index;
  logic         push;
  logic         pop;

  assign rd_valid = count_q != 2'd0;
  assign rd_data  = entry_q[0];
  assign wr_ready = (count_q != 2'd2) || rd_ready;
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;
  assign wr_index = count_q - 2'(pop);
  assign count    = count_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q    <= '0;
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else begin
      if (pop) begin
        entry_q[0] <= entry_q[1];
      end
      // Write lands after the surviving entries; overrides the shift into slot 0.
      if (push) begin
        entry_q[wr_index[0]] <= wr_data;
      end
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential pc with redirect, one-cycle-latency memory
// requests and a two-entry buffer presented to decode with valid/ready.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned memory_size         = 1024,
  parameter int unsigned memory_address_bits = $clog2(memory_size),
  parameter logic [31:0] reset_pc            = 32'h0000_0000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           redirect_valid,
  input  logic [31:0]                    redirect_pc,
  output logic                           imem_read_enable,
  output logic [memory_address_bits-3:0] imem_address,
  input  logic [31:0]                    imem_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [31:0]                    out_instruction,
  output logic [31:0]                    out_pc
);

  fetch_state_t state;
  word_t        pc_q;
  word_t        inflight_pc_q;
  word_t        redirect_target;
  logic         inflight_q;
  logic         transfer;
  logic         buf_clear;
  logic         buf_wr_valid;
  logic         buf_wr_ready;
  logic         buf_rd_valid;
  logic [1:0]   buf_count;
  fetch_entry_t buf_wr_data;
  fetch_entry_t buf_rd_data;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign imem_address    = pc_q[memory_address_bits-1:2];
  assign buf_wr_data     = '{pc: inflight_pc_q, instruction: imem_data};

  // The reset is synchronous, so RESET is exactly the cycle rst is high.
  always_comb begin
    state = rst ? RESET : RUN;
  end

  always_comb begin
    imem_read_enable = 1'b0;
    out_valid        = 1'b0;
    out_instruction  = '0;
    out_pc           = '0;
    transfer         = 1'b0;
    buf_clear        = 1'b1;
    buf_wr_valid     = 1'b0;
    case (state)
      RESET: begin
      end
      RUN: begin
        out_valid       = buf_rd_valid;
        out_instruction = buf_rd_data.instruction;
        out_pc          = buf_rd_data.pc;
        transfer        = buf_rd_valid && out_ready;
        buf_clear       = redirect_valid;
        buf_wr_valid    = inflight_q && buf_wr_ready;
        // Counting this cycle's transfer keeps one request per cycle streaming.
        imem_read_enable = !redirect_valid &&
          ((3'(buf_count) + 3'(inflight_q) - 3'(transfer)) < 3'd2);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= reset_pc;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_target;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= imem_read_enable;
      if (imem_read_enable) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + 32'd4;
      end
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk      (clk),
    .clear    (buf_clear),
    .wr_valid (buf_wr_valid),
    .wr_ready (buf_wr_ready),
    .wr_data  (buf_wr_data),
    .rd_valid (buf_rd_valid),
    .rd_ready (out_ready),
    .rd_data  (buf_rd_data),
    .count    (buf_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory word n holds n, expected streams
// are hand-computed per cycle.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_read_enable;
  logic [7:0]  imem_address;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;

  int checks = 0;
  int errors = 0;
  int req_count = 0;
  int base_req;
  int base_q;
  logic [31:0] got_pc [$];

  always #5 clk = ~clk;

  fetch_unit #(
    .memory_size (1024),
    .reset_pc    (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_read_enable (imem_read_enable),
    .imem_address     (imem_address),
    .imem_data        (imem_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instruction  (out_instruction),
    .out_pc           (out_pc)
  );

  always @(posedge clk) begin
    if (imem_read_enable) imem_data <= {24'h0, imem_address};
  end

  always @(negedge clk) begin
    if (imem_read_enable) req_count++;
    if (out_valid && out_ready) got_pc.push_back(out_pc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // Reset state and first stream
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick(); settle();
    check("rst_out_valid", out_valid, 0);
    check("rst_read_enable", imem_read_enable, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_instruction", out_instruction, 0);
    rst = 1'b0; settle();
    check("first_req", imem_read_enable, 1);
    check("first_req_addr", imem_address, 0);
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      check("stream_valid", out_valid, 1);
      check("stream_pc", out_pc, 32'(4 * i));
      check("stream_instr", out_instruction, 32'(i));
      tick();
    end

    // Backpressure: out_ready low for 5 cycles from cycle 2
    rst = 1'b1; tick();
    rst = 1'b0; out_ready = 1'b0; base_req = req_count; settle();
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", out_valid, 1);
      check("stall_pc", out_pc, 0);
      tick();
    end
    check("stall_req_count", 32'(req_count - base_req), 2);
    out_ready = 1'b1; settle();
    for (int i = 0; i < 3; i++) begin
      check("resume_pc", out_pc, 32'(4 * i));
      check("resume_instr", out_instruction, 32'(i));
      tick();
    end

    // Redirect while buffer holds 0x8, 0xC
    rst = 1'b1; out_ready = 1'b1; tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    out_ready = 1'b0; settle();
    check("fill_pc", out_pc, 32'h8);
    tick();
    check("full_pc", out_pc, 32'h8);
    redirect_valid = 1'b1; redirect_pc = 32'h40; base_q = got_pc.size(); settle();
    check("redir_no_req", imem_read_enable, 0);
    tick();
    redirect_valid = 1'b0; out_ready = 1'b1; settle();
    check("redir_valid_drop", out_valid, 0);
    check("redir_req", imem_read_enable, 1);
    check("redir_addr", imem_address, 8'h10);
    tick();
    check("redir_latency_valid", out_valid, 0);
    tick();
    // Two cycles after the redirected request
    check("redir_out_valid", out_valid, 1);
    check("redir_out_pc", out_pc, 32'h40);
    check("redir_out_instr", out_instruction, 32'h10);
    tick();
    check("redir_next_pc", out_pc, 32'h44);
    tick();
    check("redir_deliv_count", 32'(got_pc.size() - base_q), 2);
    check("redir_first_deliv", got_pc[base_q], 32'h40);

    // Unaligned redirect concurrent with a transfer
    redirect_valid = 1'b1; redirect_pc = 32'h43; base_q = got_pc.size(); settle();
    check("redir2_valid", out_valid, 1);
    check("redir2_head", out_pc, 32'h48);
    tick();
    redirect_valid = 1'b0; settle();
    check("redir2_xfer_count", 32'(got_pc.size() - base_q), 1);
    check("redir2_xfer_pc", got_pc[base_q], 32'h48);
    check("redir2_addr", imem_address, 8'h10);
    check("redir2_out_valid", out_valid, 0);
    tick(); tick();
    check("redir2_out_pc", out_pc, 32'h40);
    check("redir2_out_instr", out_instruction, 32'h10);

    // Address field wrap at memory_size
    redirect_valid = 1'b1; redirect_pc = 32'h3F8; settle();
    tick();
    redirect_valid = 1'b0; settle();
    check("wrap_addr_fe", imem_address, 8'hFE);
    tick();
    check("wrap_addr_ff", imem_address, 8'hFF);
    tick();
    check("wrap_addr_0", imem_address, 8'h00);
    check("wrap_req", imem_read_enable, 1);
    check("wrap_pc_3f8", out_pc, 32'h3F8);
    check("wrap_instr_fe", out_instruction, 32'hFE);
    tick();
    check("wrap_pc_3fc", out_pc, 32'h3FC);
    check("wrap_instr_ff", out_instruction, 32'hFF);
    tick();
    check("wrap_pc_400", out_pc, 32'h400);
    check("wrap_instr_0", out_instruction, 32'h0);

    // Mid-stream reset takes priority over a redirect
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80; settle();
    check("midrst_valid", out_valid, 0);
    check("midrst_req", imem_read_enable, 0);
    tick();
    rst = 1'b0; redirect_valid = 1'b0; settle();
    check("postrst_valid", out_valid, 0);
    check("postrst_req", imem_read_enable, 1);
    check("postrst_addr", imem_address, 8'h00);
    tick(); tick();
    check("postrst_out_valid", out_valid, 1);
    check("postrst_pc0", out_pc, 32'h0);
    check("postrst_instr0", out_instruction, 32'h0);
    tick();
    check("postrst_pc4", out_pc, 32'h4);
    check("postrst_instr1", out_instruction, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter memory_size, default 1024, instruction memory depth in bytes.
REQ-002 Parameter memory_address_bits, default $clog2(memory_size), byte-address width.
REQ-003 Parameter reset_pc, default 32'h0000_0000, first fetch address after reset.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 redirect_valid  in  1  branch/jump taken; redirect_pc is valid this cycle.
REQ-007 redirect_pc  in  32  new fetch address.
REQ-008 imem_read_enable  out  1  read request to instruction memory this cycle.
REQ-009 imem_address  out  memory_address_bits-2  word address, equal to pc[memory_address_bits-1:2].
REQ-010 imem_data  in  32  instruction word, valid exactly one cycle after its request.
REQ-011 out_valid  out  1  out_instruction/out_pc hold a fetched instruction.
REQ-012 out_ready  in  1  decode accepts the instruction this cycle.
REQ-013 out_instruction  out  32  fetched instruction word.
REQ-014 out_pc  out  32  byte address of out_instruction.

Function
REQ-015 The block shall hold a 32-bit pc register and a 2-entry instruction FIFO of {pc, instruction}.
REQ-016 A request shall issue (imem_read_enable=1) when FIFO occupancy plus in-flight requests is below 2 and redirect_valid=0; pc then advances by 4.
REQ-017 A response shall be written into the FIFO in the cycle after its request, tagged with the requesting pc.
REQ-018 out_valid shall equal FIFO-not-empty; the head entry shall drive out_instruction/out_pc; a transfer occurs when out_valid and out_ready are both 1.
REQ-019 Head data shall stay stable while out_valid=1 and out_ready=0.
REQ-020 Simultaneous FIFO write and transfer shall keep occupancy unchanged and lose no entry.
REQ-021 redirect_valid=1 shall, in that cycle: clear the FIFO, discard any in-flight response, load pc with {redirect_pc[31:2],2'b00}, and issue no request.
REQ-022 The first request after a redirect shall issue in the following cycle at the redirected address.
REQ-023 A redirect in the same cycle as a transfer shall still complete that transfer (decode saw out_valid=1).
REQ-024 pc arithmetic shall be modulo 2^32; imem_address shall truncate pc to its field, wrapping at memory_size.
REQ-025 Steady-state throughput with out_ready held 1 shall be one instruction per cycle after a 2-cycle startup latency (request cycle plus response cycle).
REQ-026 State shall be RESET, RUN: RESET for the cycle rst is 1; RUN otherwise; no other states.

Reset
REQ-027 While rst=1: pc=reset_pc, FIFO empty, in-flight cleared, out_valid=0, imem_read_enable=0, out_instruction=0, out_pc=0.
REQ-028 The first request shall issue in the first cycle with rst=0, at address reset_pc.
REQ-029 rst asserted mid-operation shall discard all FIFO contents and in-flight responses; rst shall take priority over redirect_valid.

Structure
REQ-030 The shared core package shall hold the 32-bit word width constant and the fetch-entry struct {pc, instruction}.
REQ-031 The 2-entry FIFO shall be one sub-module, fetch_buffer, with valid/ready on both sides and a synchronous clear input.
REQ-032 imem_address shall connect to the instruction-memory wiring with no added logic; write port tied off outside this block.

Verification
REQ-033 Reset release, out_ready=1, memory word n = n -> out_pc 0,4,8,12 on consecutive cycles from cycle 2, out_instruction 0,1,2,3.
REQ-034 out_ready=0 for 5 cycles from cycle 2 -> out_valid=1, out_pc held at 0, exactly 2 requests issued, then resume 0,4,8 with no loss or duplication.
REQ-035 redirect_valid=1, redirect_pc=0x40 while FIFO holds 0x8,0xC -> next out_pc 0x40 two cycles later; 0x8/0xC never delivered.
REQ-036 redirect_pc=0x43 -> imem_address=0x10, out_pc=0x40.
REQ-037 Sequential fetch with memory_size=1024 reaching pc=0x3FC -> next pc 0x400, imem_address 0; out_pc reports 0x400.
REQ-038 rst asserted for 1 cycle during streaming -> out_valid=0 next cycle; following out_pc stream restarts at reset_pc.
